datapath_control_unit: RTL and testbench

- Sequencer that drives every control input of the ALU-system datapath: RF, ARF, ALU, MUX A/B/C, IR and Memory.
- Fetches a 16-bit instruction from byte-wide memory in two cycles (low byte, then high byte), then decodes and executes it in one cycle.
- Sits beside the datapath. Its only datapath inputs are IROut and FlagsOut.

---
 rtl/datapath_control_unit.sv | 153 +++++++++++++++
 tb/tb_datapath_control_unit.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_control_unit.sv
// Instruction sequencer for the ALU-system datapath: two-cycle byte-wide fetch,
// single-cycle decode/execute, with all control outputs decoded from state and IR.
module datapath_control_unit #(
  parameter int ILLEGAL_HALTS = 0
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] IROut,
  input  logic [3:0]  FlagsOut,
  output logic [2:0]  RF_FunSel,
  output logic [2:0]  RF_OutASel,
  output logic [2:0]  RF_OutBSel,
  output logic [3:0]  RF_RegSel,
  output logic [3:0]  RF_ScrSel,
  output logic [2:0]  ARF_FunSel,
  output logic [2:0]  ARF_RegSel,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [4:0]  ALU_FunSel,
  output logic        ALU_WF,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel,
  output logic        IR_LH,
  output logic        IR_Write,
  output logic        Mem_CS,
  output logic        Mem_WR,
  output logic [2:0]  SeqState,
  output logic        Halted,
  output logic        IllegalOp
);

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_FETCH_L = 3'd1,
    S_FETCH_H = 3'd2,
    S_EXEC    = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  localparam logic [2:0] FUN_INC   = 3'b001;
  localparam logic [2:0] FUN_LOAD  = 3'b010;
  localparam logic [2:0] FUN_CLEAR = 3'b011;
  localparam logic [2:0] SEL_PC    = 3'b100;

  state_t      r_state;
  state_t      w_next;
  logic        w_take;
  logic [5:0]  w_op;
  logic        w_z;
  logic        w_unused_flags;

  assign w_op           = IROut[15:10];
  assign w_z            = FlagsOut[3];
  assign w_unused_flags = ^FlagsOut[2:0];
  assign SeqState       = r_state;
  assign Halted         = (r_state == S_HALT);

  function automatic logic [3:0] onehot(input logic [1:0] sel);
    return 4'b1000 >> sel;
  endfunction

  function automatic logic [4:0] alu_code(input logic [5:0] op);
    case (op)
      6'h05:   return 5'b10100;
      6'h06:   return 5'b10110;
      6'h07:   return 5'b10111;
      6'h08:   return 5'b11000;
      6'h09:   return 5'b11001;
      default: return 5'b10010;
    endcase
  endfunction

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) r_state <= S_INIT;
    else        r_state <= w_next;
  end

  always_comb begin
    RF_FunSel   = '0;
    RF_OutASel  = '0;
    RF_OutBSel  = '0;
    RF_RegSel   = '0;
    RF_ScrSel   = '0;
    ARF_FunSel  = '0;
    ARF_RegSel  = '0;
    ARF_OutCSel = '0;
    ARF_OutDSel = '0;
    ALU_FunSel  = '0;
    ALU_WF      = 1'b0;
    MuxASel     = '0;
    MuxBSel     = '0;
    MuxCSel     = 1'b0;
    IR_LH       = 1'b0;
    IR_Write    = 1'b0;
    Mem_CS      = 1'b1;
    Mem_WR      = 1'b0;
    IllegalOp   = 1'b0;
    w_take      = 1'b0;
    w_next      = S_INIT;
    case (r_state)
      S_INIT: begin
        ARF_RegSel = SEL_PC;
        ARF_FunSel = FUN_CLEAR;
        w_next     = S_FETCH_L;
      end
      S_FETCH_L, S_FETCH_H: begin
        Mem_CS     = 1'b0;
        IR_Write   = 1'b1;
        IR_LH      = (r_state == S_FETCH_H);
        ARF_RegSel = SEL_PC;
        ARF_FunSel = FUN_INC;
        w_next     = (r_state == S_FETCH_H) ? S_EXEC : S_FETCH_H;
      end
      S_EXEC: begin
        RF_OutASel = IROut[5:3];
        RF_OutBSel = IROut[2:0];
        w_next     = S_FETCH_L;
        case (w_op)
          6'h00: w_next = S_HALT;
          6'h01: w_take = 1'b1;
          6'h02: w_take = ~w_z;
          6'h03: w_take = w_z;
          6'h04: begin
            MuxASel   = 2'b11;
            RF_FunSel = FUN_LOAD;
            RF_RegSel = onehot(IROut[9:8]);
          end
          6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A: begin
            MuxASel    = 2'b00;
            RF_FunSel  = FUN_LOAD;
            RF_RegSel  = onehot(IROut[7:6]);
            ALU_WF     = IROut[9];
            ALU_FunSel = alu_code(w_op);
          end
          default: begin
            IllegalOp = 1'b1;
            if (ILLEGAL_HALTS != 0) w_next = S_HALT;
          end
        endcase
        // Taken branch loads PC from the zero-extended IR low byte via MUX B
        if (w_take) begin
          MuxBSel    = 2'b11;
          ARF_RegSel = SEL_PC;
          ARF_FunSel = FUN_LOAD;
        end
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_datapath_control_unit.sv
// Scoreboard bench for datapath_control_unit: both ILLEGAL_HALTS variants run side by side.
module tb_datapath_control_unit;

  typedef struct packed {
    logic [2:0] seq;
    logic       halted;
    logic       illegal;
    logic [2:0] rf_fun;
    logic [2:0] oa;
    logic [2:0] ob;
    logic [3:0] rf_reg;
    logic [3:0] scr;
    logic [2:0] arf_fun;
    logic [2:0] arf_reg;
    logic [1:0] oc;
    logic [1:0] od;
    logic [4:0] alu;
    logic       wf;
    logic [1:0] ma;
    logic [1:0] mb;
    logic       mc;
    logic       irlh;
    logic       irw;
    logic       cs;
    logic       wr;
  } ctl_t;

  logic        Clock;
  logic        Reset;
  logic [15:0] IROut;
  logic [3:0]  FlagsOut;

  logic [2:0] rf_fun [2];
  logic [2:0] rf_oa  [2];
  logic [2:0] rf_ob  [2];
  logic [3:0] rf_reg [2];
  logic [3:0] rf_scr [2];
  logic [2:0] arf_fun[2];
  logic [2:0] arf_reg[2];
  logic [1:0] arf_oc [2];
  logic [1:0] arf_od [2];
  logic [4:0] alu_fun[2];
  logic       alu_wf [2];
  logic [1:0] mux_a  [2];
  logic [1:0] mux_b  [2];
  logic       mux_c  [2];
  logic       ir_lh  [2];
  logic       ir_wr  [2];
  logic       mem_cs [2];
  logic       mem_wr [2];
  logic [2:0] seq    [2];
  logic       halted [2];
  logic       illegal[2];
  ctl_t       obs    [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    datapath_control_unit #(.ILLEGAL_HALTS(g)) u_dut (
      .Clock(Clock), .Reset(Reset), .IROut(IROut), .FlagsOut(FlagsOut),
      .RF_FunSel(rf_fun[g]), .RF_OutASel(rf_oa[g]), .RF_OutBSel(rf_ob[g]),
      .RF_RegSel(rf_reg[g]), .RF_ScrSel(rf_scr[g]),
      .ARF_FunSel(arf_fun[g]), .ARF_RegSel(arf_reg[g]),
      .ARF_OutCSel(arf_oc[g]), .ARF_OutDSel(arf_od[g]),
      .ALU_FunSel(alu_fun[g]), .ALU_WF(alu_wf[g]),
      .MuxASel(mux_a[g]), .MuxBSel(mux_b[g]), .MuxCSel(mux_c[g]),
      .IR_LH(ir_lh[g]), .IR_Write(ir_wr[g]), .Mem_CS(mem_cs[g]), .Mem_WR(mem_wr[g]),
      .SeqState(seq[g]), .Halted(halted[g]), .IllegalOp(illegal[g])
    );
    assign obs[g] = {seq[g], halted[g], illegal[g], rf_fun[g], rf_oa[g], rf_ob[g],
                     rf_reg[g], rf_scr[g], arf_fun[g], arf_reg[g], arf_oc[g], arf_od[g],
                     alu_fun[g], alu_wf[g], mux_a[g], mux_b[g], mux_c[g], ir_lh[g],
                     ir_wr[g], mem_cs[g], mem_wr[g]};
  end

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int   n_vec = 0;
  int   n_mis = 0;
  int   ms[2];
  ctl_t sb[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic ctl_t model(input int st, input logic [15:0] ir,
                                 input logic [3:0] fl, input bit halts);
    ctl_t       c;
    logic [5:0] op;
    c        = '0;
    c.cs     = 1'b1;
    c.seq    = st[2:0];
    op       = ir[15:10];
    if (st == 0) begin
      c.arf_reg = 3'b100;
      c.arf_fun = 3'b011;
    end else if (st == 1 || st == 2) begin
      c.cs      = 1'b0;
      c.irw     = 1'b1;
      c.irlh    = (st == 2);
      c.arf_reg = 3'b100;
      c.arf_fun = 3'b001;
    end else if (st == 3) begin
      c.oa = ir[5:3];
      c.ob = ir[2:0];
      if (op == 6'd1 || (op == 6'd2 && !fl[3]) || (op == 6'd3 && fl[3])) begin
        c.mb      = 2'b11;
        c.arf_reg = 3'b100;
        c.arf_fun = 3'b010;
      end else if (op == 6'd4) begin
        c.ma     = 2'b11;
        c.rf_fun = 3'b010;
        c.rf_reg = 4'b1000 >> ir[9:8];
      end else if (op >= 6'd5 && op <= 6'd10) begin
        c.rf_fun = 3'b010;
        c.rf_reg = 4'b1000 >> ir[7:6];
        c.wf     = ir[9];
        if      (op == 6'd5) c.alu = 5'b10100;
        else if (op == 6'd6) c.alu = 5'b10110;
        else if (op == 6'd7) c.alu = 5'b10111;
        else if (op == 6'd8) c.alu = 5'b11000;
        else if (op == 6'd9) c.alu = 5'b11001;
        else                 c.alu = 5'b10010;
      end else if (op >= 6'd11) begin
        c.illegal = 1'b1;
      end
    end else begin
      c.halted = 1'b1;
    end
    return c;
  endfunction

  function automatic int nxt(input int st, input logic [15:0] ir, input bit halts,
                             input logic rst_n);
    if (!rst_n) return 0;
    if (st == 0) return 1;
    if (st == 1) return 2;
    if (st == 2) return 3;
    if (st == 3) begin
      if (ir[15:10] == 6'd0) return 4;
      if (ir[15:10] >= 6'd11 && halts) return 4;
      return 1;
    end
    return 4;
  endfunction

  task automatic apply(input string tag, input logic [15:0] ir, input logic [3:0] fl);
    ctl_t e;
    IROut    = ir;
    FlagsOut = fl;
    for (int k = 0; k < 2; k++) sb.push_back(model(ms[k], ir, fl, k == 1));
    #1;
    for (int k = 0; k < 2; k++) begin
      e = sb.pop_front();
      chk($sformatf("%s.dut%0d", tag, k), obs[k], e);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    for (int k = 0; k < 2; k++) ms[k] = nxt(ms[k], IROut, k == 1, Reset);
    @(negedge Clock);
  endtask

  task automatic fetch(input logic [15:0] ir, input logic [3:0] fl);
    apply("fetch_l", ir, fl);
    tick();
    apply("fetch_h", ir, fl);
    tick();
  endtask

  task automatic run(input string tag, input logic [15:0] ir, input logic [3:0] fl);
    fetch(ir, fl);
    apply(tag, ir, fl);
    tick();
  endtask

  logic [5:0] r_op;
  logic [9:0] r_lo;
  logic [3:0] r_fl;

  initial begin
    Reset    = 1'b1;
    IROut    = '0;
    FlagsOut = '0;
    ms[0]    = 0;
    ms[1]    = 0;
    #2 Reset = 1'b0;
    @(negedge Clock);
    apply("reset", 16'h0000, 4'h0);
    tick();
    apply("reset_hold", 16'h1653, 4'hF);
    tick();
    Reset = 1'b1;
    apply("init", 16'h0000, 4'h0);
    tick();

    fetch(16'h1653, 4'h0);
    apply("exec_add", 16'h1653, 4'h0);
    chk("add_alu_fun", alu_fun[0], 5'b10100);
    chk("add_wf", alu_wf[0], 1'b1);
    chk("add_outa", rf_oa[0], 3'b010);
    chk("add_outb", rf_ob[0], 3'b011);
    chk("add_regsel", rf_reg[0], 4'b0100);
    chk("add_muxa", mux_a[0], 2'b00);
    tick();

    fetch(16'h0820, 4'h0);
    apply("exec_bne_nz", 16'h0820, 4'h0);
    chk("bne_nz_muxb", mux_b[0], 2'b11);
    chk("bne_nz_arfreg", arf_reg[0], 3'b100);
    chk("bne_nz_arffun", arf_fun[0], 3'b010);
    tick();
    fetch(16'h0820, 4'h8);
    apply("exec_bne_z", 16'h0820, 4'h8);
    chk("bne_z_arfreg", arf_reg[0], 3'b000);
    tick();

    run("exec_bra", 16'h0455, 4'h0);
    run("exec_beq_z", 16'h0C12, 4'h8);
    run("exec_beq_nz", 16'h0C12, 4'h7);
    run("exec_movl", 16'h13A5, 4'h0);
    run("exec_sub", 16'h18C1, 4'h0);
    run("exec_and", 16'h1E3A, 4'h0);
    run("exec_orr", 16'h2040, 4'h0);
    run("exec_xor", 16'h2680, 4'h0);
    run("exec_not", 16'h28FF, 4'h0);

    for (int i = 0; i < 20; i++) begin
      r_op = 6'($urandom_range(1, 10));
      r_lo = 10'($urandom_range(0, 1023));
      r_fl = 4'($urandom_range(0, 15));
      run("exec_rand", {r_op, r_lo}, r_fl);
    end

    apply("fetch_l", 16'h1653, 4'h0);
    tick();
    apply("fetch_h", 16'h1653, 4'h0);
    Reset = 1'b0;
    #1;
    chk("async_rst_seq", seq[0], 3'd0);
    ms[0] = 0;
    ms[1] = 0;
    apply("rst_init", 16'h1653, 4'h0);
    tick();
    Reset = 1'b1;
    apply("init_after_rst", 16'h1653, 4'h0);
    chk("init_arfreg", arf_reg[0], 3'b100);
    chk("init_arffun", arf_fun[0], 3'b011);
    tick();
    apply("seq_fl", 16'h1653, 4'h0);
    chk("seq_1", seq[0], 3'd1);
    tick();
    apply("seq_fh", 16'h1653, 4'h0);
    chk("seq_2", seq[0], 3'd2);
    tick();
    apply("seq_ex", 16'h1653, 4'h0);
    chk("seq_3", seq[0], 3'd3);
    tick();

    fetch(16'h2C00, 4'h0);
    apply("exec_illegal", 16'h2C00, 4'h0);
    chk("ill_pulse0", illegal[0], 1'b1);
    chk("ill_pulse1", illegal[1], 1'b1);
    tick();
    apply("post_illegal", 16'h2C00, 4'h0);
    chk("ill_clear0", illegal[0], 1'b0);
    chk("ill_fetch0", seq[0], 3'd1);
    chk("ill_halt1", halted[1], 1'b1);
    tick();
    apply("fetch_h", 16'h0000, 4'h0);
    tick();

    apply("exec_hlt", 16'h0000, 4'h0);
    tick();
    for (int i = 0; i < 12; i++) begin
      apply("halt", 16'($urandom), 4'($urandom_range(0, 15)));
      tick();
    end
    chk("hlt_halted", halted[0], 1'b1);
    chk("hlt_cs", mem_cs[0], 1'b1);
    Reset = 1'b0;
    #1;
    chk("hlt_exit0", seq[0], 3'd0);
    chk("hlt_exit1", seq[1], 3'd0);
    ms[0] = 0;
    ms[1] = 0;
    apply("rst_from_halt", 16'h0000, 4'h0);
    tick();
    Reset = 1'b1;
    apply("init_final", 16'h0000, 4'h0);
    tick();
    run("exec_final", 16'h1653, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
